// File: rtl/edf_pkg.sv
// Shared types and constants for the EDF arbiter and its gateway cells.
package edf_pkg;

  localparam int EdfTsWidth = 64;

  typedef enum logic {
    ARB_SCAN  = 1'b0,
    ARB_CLAIM = 1'b1
  } arb_state_e;

endpackage

// File: rtl/edf_arbiter.sv
// Earliest-deadline-first arbiter: sweeps one gateway per cycle and presents the
// pending source with the smallest deadline. Optional macro EDF_ARB_PREEMPT_EN.
module edf_arbiter
  import edf_pkg::*;
#(
  parameter int NrSrc   = 32,
  parameter int TsWidth = EdfTsWidth,
  parameter int IdWidth = $clog2(NrSrc)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NrSrc-1:0][TsWidth-1:0]   dl_i,
  input  logic [NrSrc-1:0]                ip_i,
  output logic [NrSrc-1:0]                claim_o,
  output logic                            irq_o,
  output logic [IdWidth-1:0]              irq_id_o,
  output logic [TsWidth-1:0]              irq_dl_o,
  input  logic                            irq_ack_i
);

  localparam logic [IdWidth-1:0] LastIdx = IdWidth'(NrSrc - 1);

  arb_state_e           state_q, state_d;
  logic [IdWidth-1:0]   idx_q, idx_d;
  logic                 pub_q, pub_d;
  logic                 best_vld_q, best_vld_d;
  logic [IdWidth-1:0]   best_id_q, best_id_d;
  logic [TsWidth-1:0]   best_dl_q, best_dl_d;
  logic                 irq_q, irq_d;
  logic [IdWidth-1:0]   irq_id_q, irq_id_d;
  logic [TsWidth-1:0]   irq_dl_q, irq_dl_d;
  logic [NrSrc-1:0]     claim_q, claim_d;
  logic                 held;

  // The publish cycle also visits idx 0, so the old best must not carry over.
  assign held = best_vld_q && !pub_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pub_d      = 1'b0;
    best_vld_d = best_vld_q;
    best_id_d  = best_id_q;
    best_dl_d  = best_dl_q;
    irq_d      = irq_q;
    irq_id_d   = irq_id_q;
    irq_dl_d   = irq_dl_q;
    claim_d    = '0;

    if (state_q == ARB_CLAIM) begin
      state_d    = ARB_SCAN;
      idx_d      = '0;
      best_vld_d = 1'b0;
    end else if (irq_q && irq_ack_i) begin
      state_d           = ARB_CLAIM;
      claim_d[irq_id_q] = 1'b1;
      irq_d             = 1'b0;
      idx_d             = '0;
      best_vld_d        = 1'b0;
    end else begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
      pub_d = (idx_q == LastIdx);

      if (ip_i[idx_q] && (!held || dl_i[idx_q] < best_dl_q)) begin
        best_vld_d = 1'b1;
        best_id_d  = idx_q;
        best_dl_d  = dl_i[idx_q];
      end else if (!held) begin
        best_vld_d = 1'b0;
      end

      if (irq_q && !ip_i[irq_id_q]) irq_d = 1'b0;

      if (pub_q) begin
        if (!irq_q) begin
          if (best_vld_q) begin
            irq_d    = 1'b1;
            irq_id_d = best_id_q;
            irq_dl_d = best_dl_q;
          end
        end
`ifdef EDF_ARB_PREEMPT_EN
        else if (best_vld_q && best_dl_q < irq_dl_q) begin
          irq_d    = 1'b1;
          irq_id_d = best_id_q;
          irq_dl_d = best_dl_q;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB_SCAN;
      idx_q      <= '0;
      pub_q      <= 1'b0;
      best_vld_q <= 1'b0;
      best_id_q  <= '0;
      best_dl_q  <= '0;
      irq_q      <= 1'b0;
      irq_id_q   <= '0;
      irq_dl_q   <= '0;
      claim_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pub_q      <= pub_d;
      best_vld_q <= best_vld_d;
      best_id_q  <= best_id_d;
      best_dl_q  <= best_dl_d;
      irq_q      <= irq_d;
      irq_id_q   <= irq_id_d;
      irq_dl_q   <= irq_dl_d;
      claim_q    <= claim_d;
    end
  end

  assign claim_o  = claim_q;
  assign irq_o    = irq_q;
  assign irq_id_o = irq_id_q;
  assign irq_dl_o = irq_dl_q;

endmodule

// File: tb/tb_edf_arbiter.sv
// Directed bench for edf_arbiter with NrSrc=4; inputs change and outputs are sampled on negedge.
module tb_edf_arbiter;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0][63:0] dl = '0;
  logic [N-1:0]      ip = '0;
  logic [N-1:0]      claim;
  logic              irq;
  logic [1:0]        irq_id;
  logic [63:0]       irq_dl;
  logic              ack = 1'b0;
  int                npass = 0;
  int                ntot = 0;

  edf_arbiter #(.NrSrc(N), .TsWidth(64)) dut (
    .clk_i(clk), .rst_i(rst), .dl_i(dl), .ip_i(ip), .claim_o(claim),
    .irq_o(irq), .irq_id_o(irq_id), .irq_dl_o(irq_dl), .irq_ack_i(ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; ip = '0; dl = '0; ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns number of negedges waited; budget covers worst-case 2N+1 latency.
  task automatic wait_irq(input string tag, output int n);
    n = 0;
    while (!irq && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, irq, 1);
  endtask

  // Ack the presented source, model the gateway clearing its pending bit on claim.
  task automatic do_ack(input string tag, input logic [N-1:0] exp_claim);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk({tag, "_claim"}, claim, exp_claim);
    chk({tag, "_irq0"}, irq, 0);
    ip = ip & ~claim;
    @(negedge clk);
    chk({tag, "_claim_end"}, claim, 0);
  endtask

  initial begin
    int n;
    // Reset state and exact fresh-sweep latency
    rst = 1'b1;
    #1;
    chk("rst_claim", claim, 0);
    chk("rst_irq", irq, 0);
    chk("rst_id", irq_id, 0);
    chk("rst_dl", irq_dl, 0);
    @(negedge clk);
    ip = 4'b0001; dl[0] = 64'd9;
    rst = 1'b0;
    wait_irq("lat_irq", n);
    chk("lat_cycles", n, N + 1);

    // Single source
    do_reset();
    ip = 4'b0100; dl[2] = 64'd100;
    wait_irq("single_irq", n);
    chk("single_id", irq_id, 2);
    chk("single_dl", irq_dl, 100);
    do_ack("single", 4'b0100);
    repeat (12) @(negedge clk);
    chk("single_quiet", irq, 0);

    // EDF order with full-width deadline
    do_reset();
    dl[0] = 64'd500; dl[1] = 64'd200; dl[3] = 64'd300; dl[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    ip = 4'b1011;
    wait_irq("edf1_irq", n);
    chk("edf1_id", irq_id, 1);
    chk("edf1_dl", irq_dl, 200);
    do_ack("edf1", 4'b0010);
    wait_irq("edf2_irq", n);
    chk("edf2_id", irq_id, 3);
    do_ack("edf2", 4'b1000);
    wait_irq("edf3_irq", n);
    chk("edf3_id", irq_id, 0);
    chk("edf3_dl", irq_dl, 500);
    do_ack("edf3", 4'b0001);

    // Tie keeps the lower index
    do_reset();
    dl[1] = 64'd77; dl[3] = 64'd77;
    ip = 4'b1010;
    wait_irq("tie_irq", n);
    chk("tie_id", irq_id, 1);

    // Withdraw
    do_reset();
    ip = 4'b0001; dl[0] = 64'd5;
    wait_irq("wd_irq", n);
    chk("wd_id", irq_id, 0);
    ip = 4'b0000;
    @(negedge clk);
    chk("wd_drop", irq, 0);
    chk("wd_noclaim", claim, 0);
    repeat (10) @(negedge clk);
    chk("wd_quiet", irq, 0);
    chk("wd_claim_quiet", claim, 0);
    chk("wd_id_hold", irq_id, 0);
    chk("wd_dl_hold", irq_dl, 5);

    // Ack ignored while idle
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("idle_ack_claim", claim, 0);

    // Reset mid-claim
    do_reset();
    ip = 4'b0001; dl[0] = 64'd42;
    wait_irq("rc_irq", n);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("rc_claim", claim, 4'b0001);
    rst = 1'b1;
    #1;
    chk("rc_claim_clr", claim, 0);
    chk("rc_irq_clr", irq, 0);
    chk("rc_id_clr", irq_id, 0);
    chk("rc_dl_clr", irq_dl, 0);

    // Hold vs preempt
    do_reset();
    ip = 4'b0100; dl[2] = 64'd900;
    wait_irq("hp_irq", n);
    chk("hp_id0", irq_id, 2);
    dl[0] = 64'd50;
    ip = 4'b0101;
    repeat (2 * N + 2) @(negedge clk);
    chk("hp_irq_on", irq, 1);
`ifdef EDF_ARB_PREEMPT_EN
    chk("hp_id", irq_id, 0);
    chk("hp_dl", irq_dl, 50);
`else
    chk("hp_id", irq_id, 2);
    chk("hp_dl", irq_dl, 900);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/edf_arbiter.md
# edf_arbiter

Earliest-deadline-first arbiter sitting between the per-source gateway cells and the hart interrupt port. It sweeps the pending flags and absolute deadlines of all gateways, selects the pending source with the smallest deadline, and presents it to the hart. On hart acknowledge it pulses the one-hot claim line back to the selected gateway, which clears that gateway's pending state.

## Interface
- `NrSrc`, 32: number of gateway cells, ≥2.
- `TsWidth`, 64: deadline width; matches the gateway `dl_o`.
- `IdWidth`, `$clog2(NrSrc)`: source index width.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `dl_i`  in  NrSrc×TsWidth  absolute deadline per source, from gateway `dl_o`.
- `ip_i`  in  NrSrc  pending per source, from gateway `ip_o`.
- `claim_o`  out  NrSrc  one-hot claim pulse, to gateway `claim_i`.
- `irq_o`  out  1  interrupt request to the hart.
- `irq_id_o`  out  IdWidth  index of the presented source.
- `irq_dl_o`  out  TsWidth  deadline of the presented source.
- `irq_ack_i`  in  1  hart takes the presented interrupt; single-cycle pulse.

## Operation
- FSM states: `ARB_SCAN`, `ARB_CLAIM`. Reset state is `ARB_SCAN` with scan index 0 and no best candidate.
- **ARB_SCAN:**
  - Visits one index per cycle, 0..NrSrc-1, using a counter.
  - A visited source becomes the best candidate if `ip_i[idx]`=1 and either no candidate is held or `dl_i[idx]` < the best deadline.
  - The comparison is unsigned and full TsWidth.
  - Ties keep the lower index. Deadline values are never wrapped.
  - Inputs are sampled only at the visit. Changes to a source after its visit take effect in the next sweep.
- **End of sweep (publish):** happens in the cycle after index NrSrc-1 is visited. The counter returns to 0 and the next sweep starts in that same cycle.
  - If `irq_o`=0: a found candidate loads `irq_id_o` and `irq_dl_o` and sets `irq_o`=1. If no candidate is found, outputs are unchanged and `irq_o` stays 0.
  - If `irq_o`=1: the result is discarded. (See Configuration for the exception.)
- **Withdrawn interrupt:** while `irq_o`=1, if `ip_i[irq_id_o]` falls to 0 (software cleared the gateway), `irq_o` drops in the next cycle. `irq_id_o` and `irq_dl_o` hold their values. The current sweep continues.
- **Acknowledge:** `irq_ack_i`=1 while `irq_o`=1 takes priority over a withdrawal in the same cycle. In the next cycle:
  - `claim_o` is one-hot at `irq_id_o`;
  - `irq_o` is 0;
  - the FSM is in `ARB_CLAIM`; the partial sweep is discarded.
- `irq_ack_i` while `irq_o`=0 is ignored.
- **ARB_CLAIM:** lasts exactly one cycle. `claim_o` is cleared and the FSM enters `ARB_SCAN` with index 0 and no candidate held. The claimed gateway's pending flag is already low at that first visit.

## Timing
- All outputs are registered.
- Reset values: `claim_o`=0, `irq_o`=0, `irq_id_o`=0, `irq_dl_o`=0.
- Latency from a pending edge to `irq_o` (idle arbiter): at most 2·NrSrc+1 cycles; exactly NrSrc+1 if the source is visited at idx 0 of a fresh sweep.
- Ack at cycle t: `claim_o` pulse at t+1, sweep restarts at t+2, and the next `irq_o` no earlier than t+2+NrSrc.
- Asserting `rst_i` mid-sweep or mid-claim returns everything to the reset state immediately. No `claim_o` is left asserted.

## Configuration
- `EDF_ARB_PREEMPT_EN` defined:
  - At publish with `irq_o`=1, if the candidate deadline is strictly less than `irq_dl_o`, then `irq_id_o` and `irq_dl_o` are replaced and `irq_o` stays 1.
  - An ack in the publish cycle claims the old `irq_id_o` and discards the candidate.
- `EDF_ARB_PREEMPT_EN` undefined: the presented interrupt is held until ack or withdrawal.

## Structure
- `edf_pkg` holds:
  - `arb_state_e` (`ARB_SCAN`, `ARB_CLAIM`);
  - the default constant `EdfTsWidth` = 64, shared with the gateway.
- No sub-module. The counter, best-candidate register and comparator are inline.

## Test plan
All scenarios use NrSrc=4.
- **Single source:** after reset, src2 pending with dl=100 → `irq_o`=1, `irq_id_o`=2, `irq_dl_o`=100. Ack → `claim_o`=4'b0100 for one cycle, and `irq_o` stays 0 afterwards.
- **EDF select:** src0 dl=500, src1 dl=200, src3 dl=300 all pending → src1 presented. After ack, src3 is presented; after its ack, src0.
- **Tie:** src1 and src3 both dl=77 → `irq_id_o`=1.
- **Withdraw:** src0 presented, then `ip_i[0]` dropped → `irq_o`=0 the next cycle, and no `claim_o`.
- **Reset mid-claim:** `rst_i` in the cycle `claim_o`=4'b0001 → `claim_o`=0 and `irq_o`=0 immediately.
- **Hold vs. preempt:** src2 presented with dl=900, then src0 becomes pending with dl=50 and no ack.
  - Macro undefined: `irq_id_o` stays 2.
  - `EDF_ARB_PREEMPT_EN` defined: `irq_id_o` becomes 0 with `irq_dl_o`=50 at the next publish.
